// File: rtl/any1_tlb_sa.sv
`default_nettype none
// ============================================================================
// Module   : any1_tlb_sa
// Purpose  : Set-associative TLB with 1-cycle lookup, software read/write,
//            round-robin write way, INIT/FLUSH set walks. Optional hardware
//            A/D update is enabled by defining ANY1_TLB_ADUPD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module any1_tlb_sa #(
    parameter int AWID   = 32,
    parameter int PGBITS = 14,
    parameter int SETS   = 64,
    parameter int WAYS   = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     xlaten_i,
    input  logic                     req_i,
    input  logic                     we_i,
    input  logic [7:0]               asid_i,
    input  logic [AWID-1:0]          vadr_i,
    output logic                     rdy_o,
    output logic                     vld_o,
    output logic [AWID-1:0]          padr_o,
    output logic [3:0]               acr_o,
    output logic                     miss_o,
    input  logic                     wr_i,
    input  logic                     rd_i,
    input  logic                     wrand_i,
    input  logic [$clog2(WAYS)-1:0]  wway_i,
    input  logic [$clog2(SETS)-1:0]  wset_i,
    input  logic [63:0]              wdat_i,
    output logic [63:0]              rdat_o,
    input  logic                     flush_i,
    input  logic                     flasid_i
);

    localparam int c_SB = $clog2(SETS);
    localparam int c_WB = $clog2(WAYS);
    localparam int c_PW = AWID - PGBITS;
    localparam int c_TW = AWID - PGBITS - c_SB;

    typedef enum logic [1:0] {
        c_INIT  = 2'd0,
        c_RUN   = 2'd1,
        c_FLUSH = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_SB-1:0]    r_cnt;
    logic [c_WB-1:0]    r_rr_way;
    logic [7:0]         r_fl_asid;
    logic               r_fl_sel;
    logic               r_vld;
    logic               r_miss;
    logic [AWID-1:0]    r_padr;
    logic [3:0]         r_acr;
    logic [63:0]        r_rdat;

    // Entry: V G D A C R W X | ASID | tag in the upper bits of [47:24] | PPN low-aligned
    logic [63:0]        r_mem [SETS][WAYS];

    logic [c_SB-1:0]    w_lk_set;
    logic [c_TW-1:0]    w_lk_tag;
    logic [WAYS-1:0]    w_hit_vec;
    logic               w_hit;
    logic [c_WB-1:0]    w_hit_way;
    logic [WAYS-1:0]    w_fl_vec;
    logic               w_req_acc;
    logic               w_wr_acc;
    logic               w_rd_acc;
    logic               w_cnt_last;
    logic [c_WB-1:0]    w_wr_way;

    assign rdy_o      = (r_state == c_RUN);
    assign w_req_acc  = rdy_o & req_i & ~flush_i;
    assign w_wr_acc   = rdy_o & wr_i;
    assign w_rd_acc   = rdy_o & rd_i;
    assign w_cnt_last = (r_cnt == c_SB'(SETS - 1));
    assign w_wr_way   = wrand_i ? r_rr_way : wway_i;
    assign w_lk_set   = vadr_i[PGBITS+c_SB-1:PGBITS];
    assign w_lk_tag   = vadr_i[AWID-1:PGBITS+c_SB];

    assign vld_o  = r_vld;
    assign miss_o = r_miss;
    assign padr_o = r_padr;
    assign acr_o  = r_acr;
    assign rdat_o = r_rdat;

    always_comb begin
        w_hit_vec = '0;
        w_fl_vec  = '0;
        for (int w = 0; w < WAYS; w++) begin
            w_hit_vec[w] = r_mem[w_lk_set][c_WB'(w)][63]
                         && (r_mem[w_lk_set][c_WB'(w)][47 -: c_TW] == w_lk_tag)
                         && (r_mem[w_lk_set][c_WB'(w)][62]
                             || (r_mem[w_lk_set][c_WB'(w)][55:48] == asid_i));
            w_fl_vec[w]  = !r_fl_sel
                         || (!r_mem[r_cnt][c_WB'(w)][62]
                             && (r_mem[r_cnt][c_WB'(w)][55:48] == r_fl_asid));
        end
    end

    // Scan downwards so the lowest matching way is the one left selected
    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (w_hit_vec[w]) begin
                w_hit     = 1'b1;
                w_hit_way = c_WB'(w);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_INIT:  if (w_cnt_last) w_state_nxt = c_RUN;
            c_RUN:   if (flush_i) w_state_nxt = c_FLUSH;
            c_FLUSH: if (w_cnt_last) w_state_nxt = c_RUN;
            default: w_state_nxt = c_INIT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= c_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= (r_state == c_RUN) ? '0 : r_cnt + 1'b1;
        end
    end

`ifdef ANY1_TLB_ADUPD_EN
    logic               r_ad_pend;
    logic               r_ad_we;
    logic [c_SB-1:0]    r_ad_set;
    logic [c_WB-1:0]    r_ad_way;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ad_pend <= 1'b0;
            r_ad_we   <= 1'b0;
            r_ad_set  <= '0;
            r_ad_way  <= '0;
        end else begin
            r_ad_pend <= w_req_acc & xlaten_i & w_hit;
            if (w_req_acc) begin
                r_ad_we  <= we_i;
                r_ad_set <= w_lk_set;
                r_ad_way <= w_hit_way;
            end
        end
    end
`else
    logic w_unused_we;
    assign w_unused_we = we_i;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr_way  <= '0;
            r_fl_asid <= '0;
            r_fl_sel  <= 1'b0;
            r_vld     <= 1'b0;
            r_miss    <= 1'b0;
            r_padr    <= '0;
            r_acr     <= '0;
            r_rdat    <= '0;
        end else begin
            r_vld <= w_req_acc;
            if (rdy_o && flush_i) begin
                r_fl_asid <= asid_i;
                r_fl_sel  <= flasid_i;
            end
            if (w_wr_acc && wrand_i)
                r_rr_way <= r_rr_way + 1'b1;
            if (w_rd_acc)
                r_rdat <= r_mem[wset_i][wway_i];
            if (w_req_acc) begin
                if (!xlaten_i) begin
                    r_padr <= vadr_i;
                    r_acr  <= 4'hF;
                    r_miss <= 1'b0;
                end else if (w_hit) begin
                    r_padr <= {r_mem[w_lk_set][w_hit_way][c_PW-1:0], vadr_i[PGBITS-1:0]};
                    r_acr  <= r_mem[w_lk_set][w_hit_way][59:56];
                    r_miss <= 1'b0;
                end else begin
                    r_padr <= '0;
                    r_acr  <= '0;
                    r_miss <= 1'b1;
                end
            end
        end
    end

    // Later assignments win: A/D marking, then V clearing, then a software write
    always_ff @(posedge clk_i) begin
`ifdef ANY1_TLB_ADUPD_EN
        if (r_ad_pend) begin
            r_mem[r_ad_set][r_ad_way][60] <= 1'b1;
            if (r_ad_we)
                r_mem[r_ad_set][r_ad_way][61] <= 1'b1;
        end
`endif
        for (int w = 0; w < WAYS; w++) begin
            if ((r_state == c_INIT) || ((r_state == c_FLUSH) && w_fl_vec[w]))
                r_mem[r_cnt][c_WB'(w)][63] <= 1'b0;
        end
        if (w_wr_acc)
            r_mem[wset_i][w_wr_way] <= wdat_i;
    end

endmodule
`default_nettype wire

// File: tb/tb_any1_tlb_sa.sv
`default_nettype none
// ============================================================================
// Module   : tb_any1_tlb_sa
// Purpose  : Randomised self-checking bench for any1_tlb_sa against a
//            table-based TLB model; honours ANY1_TLB_ADUPD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_any1_tlb_sa;

`ifdef ANY1_TLB_ADUPD_EN
    localparam bit ADUPD = 1'b1;
`else
    localparam bit ADUPD = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni, xlaten_i, req_i, we_i;
    logic [7:0]  asid_i;
    logic [31:0] vadr_i;
    logic        rdy_o, vld_o, miss_o;
    logic [31:0] padr_o;
    logic [3:0]  acr_o;
    logic        wr_i, rd_i, wrand_i;
    logic [1:0]  wway_i;
    logic [5:0]  wset_i;
    logic [63:0] wdat_i, rdat_o;
    logic        flush_i, flasid_i;

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    any1_tlb_sa #(.AWID(32), .PGBITS(14), .SETS(64), .WAYS(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .xlaten_i(xlaten_i), .req_i(req_i),
        .we_i(we_i), .asid_i(asid_i), .vadr_i(vadr_i), .rdy_o(rdy_o),
        .vld_o(vld_o), .padr_o(padr_o), .acr_o(acr_o), .miss_o(miss_o),
        .wr_i(wr_i), .rd_i(rd_i), .wrand_i(wrand_i), .wway_i(wway_i),
        .wset_i(wset_i), .wdat_i(wdat_i), .rdat_o(rdat_o),
        .flush_i(flush_i), .flasid_i(flasid_i)
    );

    // Reference model: a 64x4 table of entries plus round-robin pointer
    logic [63:0] mm [64][4];
    bit          known [64][4];
    int          rr;
    bit          pend, pwe;
    int          pset, pway;
    logic        exp_vld, exp_miss;
    logic [31:0] exp_padr;
    logic [3:0]  exp_acr;
    logic [63:0] exp_rdat;
    bit          rdat_known;

    function automatic logic [63:0] mk(input bit v, input bit g, input logic [3:0] crwx,
                                       input logic [7:0] asid, input logic [11:0] tag,
                                       input logic [17:0] ppn, input logic [1:0] da);
        return {v, g, da, crwx, asid, tag, 12'h000, 6'h00, ppn};
    endfunction

    function automatic int find(input logic [31:0] va, input logic [7:0] asid);
        int s;
        s = int'(va[19:14]);
        for (int w = 0; w < 4; w++)
            if (mm[s][w][63] && mm[s][w][47:36] == va[31:20] && (mm[s][w][62] || mm[s][w][55:48] == asid))
                return w;
        return -1;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < 64; s++)
            for (int w = 0; w < 4; w++) begin
                mm[s][w] = '0;
                known[s][w] = 1'b0;
            end
        rr = 0; pend = 0; pwe = 0; pset = 0; pway = 0;
        exp_vld = 0; exp_miss = 0; exp_padr = '0; exp_acr = '0; exp_rdat = '0; rdat_known = 1;
    endtask

    // One accepted RUN-state clock edge applied to the model
    task automatic model_edge();
        int w, s;
        bit np, nwe;
        int ns, nw;
        np = 0; nwe = 0; ns = 0; nw = 0;
        exp_vld = req_i && !flush_i;
        if (exp_vld) begin
            if (!xlaten_i) begin
                exp_padr = vadr_i; exp_acr = 4'hF; exp_miss = 0;
            end else begin
                w = find(vadr_i, asid_i);
                s = int'(vadr_i[19:14]);
                if (w >= 0) begin
                    exp_padr = {mm[s][w][17:0], vadr_i[13:0]};
                    exp_acr  = mm[s][w][59:56];
                    exp_miss = 0;
                    np = 1; ns = s; nw = w; nwe = we_i;
                end else begin
                    exp_padr = '0; exp_acr = '0; exp_miss = 1;
                end
            end
        end
        if (rd_i) begin
            exp_rdat   = mm[int'(wset_i)][int'(wway_i)];
            rdat_known = known[int'(wset_i)][int'(wway_i)];
        end
        if (ADUPD && pend) begin
            mm[pset][pway][60] = 1'b1;
            if (pwe) mm[pset][pway][61] = 1'b1;
        end
        if (wr_i) begin
            w = wrand_i ? rr : int'(wway_i);
            mm[int'(wset_i)][w]    = wdat_i;
            known[int'(wset_i)][w] = 1'b1;
            if (wrand_i) rr = (rr + 1) % 4;
        end
        pend = np; pset = ns; pway = nw; pwe = nwe;
    endtask

    task automatic idle();
        xlaten_i = 1; req_i = 0; we_i = 0; wr_i = 0; rd_i = 0; wrand_i = 0;
        flush_i = 0; flasid_i = 0;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic cyc();
        model_edge();
        step();
    endtask

    task automatic wr_entry(input int s, input int w, input logic [63:0] d);
        wr_i = 1; wrand_i = 0; wset_i = 6'(s); wway_i = 2'(w); wdat_i = d;
        cyc();
        idle();
    endtask

    task automatic lookup(input logic [31:0] va, input logic [7:0] asid, input bit st);
        req_i = 1; xlaten_i = 1; vadr_i = va; asid_i = asid; we_i = st;
        cyc();
        idle();
    endtask

    task automatic rd_entry(input int s, input int w);
        rd_i = 1; wset_i = 6'(s); wway_i = 2'(w);
        cyc();
        idle();
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (rdy_o !== 1'b1 && n < 200) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        bit seen;
        idle(); asid_i = 0; vadr_i = 0; wset_i = 0; wway_i = 0; wdat_i = 0;
        rst_ni = 0;
        step(); step();
        checks++;
        if (rdy_o !== 0 || vld_o !== 0 || miss_o !== 0) begin
            failures++; $display("FAIL reset_ctl got rdy=%b vld=%b miss=%b want 0 0 0", rdy_o, vld_o, miss_o);
        end
        checks++;
        if (padr_o !== 0 || acr_o !== 0 || rdat_o !== 0) begin
            failures++; $display("FAIL reset_data got padr=%h acr=%h rdat=%h want 0", padr_o, acr_o, rdat_o);
        end
        rst_ni = 1;
        repeat (20) step();
        checks++;
        if (rdy_o !== 0) begin
            failures++; $display("FAIL init_busy got rdy=%b want 0", rdy_o);
        end
        rst_ni = 0;
        step();
        rst_ni = 1;
        model_reset();
        req_i = 1; flush_i = 1; wr_i = 1; vadr_i = $urandom;
        n = 0; seen = 0;
        while (rdy_o !== 1'b1 && n < 200) begin
            step();
            n++;
            if (vld_o) seen = 1;
        end
        idle();
        checks++;
        if (n != 64) begin
            failures++; $display("FAIL init_len got %0d busy cycles want 64", n);
        end
        checks++;
        if (seen) begin
            failures++; $display("FAIL init_ignore got vld during INIT want none");
        end
        for (int i = 0; i < 4; i++) begin
            lookup($urandom, 8'($urandom), 0);
            checks++;
            if (vld_o !== 1 || miss_o !== 1 || padr_o !== 0 || acr_o !== 0) begin
                failures++;
                $display("FAIL empty_miss[%0d] got vld=%b miss=%b padr=%h acr=%h want 1 1 0 0", i, vld_o, miss_o, padr_o, acr_o);
            end
        end
    endtask

    task automatic test_rrway();
        logic [63:0] d [5];
        logic [63:0] e;
        for (int k = 0; k < 5; k++) begin
            d[k] = mk(0, 0, 4'(k), 8'(k + 1), 12'($urandom), 18'($urandom), 2'b00);
            wr_i = 1; wrand_i = 1; wset_i = 6'd20; wway_i = 2'($urandom); wdat_i = d[k];
            cyc();
        end
        idle();
        for (int w = 0; w < 4; w++) begin
            rd_entry(20, w);
            e = (w == 0) ? d[4] : d[w];
            checks++;
            if (rdat_o !== e) begin
                failures++; $display("FAIL rr_way[%0d] got %h want %h", w, rdat_o, e);
            end
        end
        cyc();
        checks++;
        if (rdat_o !== d[3]) begin
            failures++; $display("FAIL rdat_hold got %h want %h", rdat_o, d[3]);
        end
    endtask

    task automatic test_write_lookup();
        logic [11:0] t;
        logic [13:0] off;
        t = 12'($urandom); off = 14'($urandom);
        wr_entry(5, 2, mk(1, 0, 4'hE, 8'h12, t, 18'h0003A, 2'b00));
        lookup({t, 6'd5, off}, 8'h12, 0);
        checks++;
        if (vld_o !== 1 || padr_o !== {18'h0003A, off} || acr_o !== 4'hE || miss_o !== 0) begin
            failures++;
            $display("FAIL asid_hit got vld=%b padr=%h acr=%h miss=%b want 1 %h e 0", vld_o, padr_o, acr_o, miss_o, {18'h0003A, off});
        end
        cyc();
        checks++;
        if (vld_o !== 0 || padr_o !== {18'h0003A, off} || acr_o !== 4'hE) begin
            failures++; $display("FAIL out_hold got vld=%b padr=%h acr=%h want 0 %h e", vld_o, padr_o, acr_o, {18'h0003A, off});
        end
        lookup({t, 6'd5, off}, 8'h13, 0);
        checks++;
        if (vld_o !== 1 || miss_o !== 1 || padr_o !== 0 || acr_o !== 0) begin
            failures++; $display("FAIL asid_miss got vld=%b miss=%b padr=%h acr=%h want 1 1 0 0", vld_o, miss_o, padr_o, acr_o);
        end
        wr_i = 1; wset_i = 6'd5; wway_i = 2'd2; wdat_i = mk(1, 0, 4'hE, 8'h12, t, 18'h0003B, 2'b00);
        lookup({t, 6'd5, off}, 8'h12, 0);
        checks++;
        if (padr_o !== {18'h0003A, off}) begin
            failures++; $display("FAIL prewrite got padr=%h want %h", padr_o, {18'h0003A, off});
        end
        lookup({t, 6'd5, off}, 8'h12, 0);
        checks++;
        if (padr_o !== {18'h0003B, off}) begin
            failures++; $display("FAIL postwrite got padr=%h want %h", padr_o, {18'h0003B, off});
        end
    endtask

    task automatic test_priority();
        logic [11:0] t;
        logic [13:0] off;
        t = 12'($urandom); off = 14'($urandom);
        wr_entry(9, 1, mk(1, 1, 4'h5, 8'h77, t, 18'h00111, 2'b00));
        wr_entry(9, 3, mk(1, 1, 4'hA, 8'h77, t, 18'h00333, 2'b00));
        lookup({t, 6'd9, off}, 8'($urandom), 0);
        checks++;
        if (padr_o !== {18'h00111, off} || acr_o !== 4'h5) begin
            failures++; $display("FAIL low_way got padr=%h acr=%h want %h 5", padr_o, acr_o, {18'h00111, off});
        end
        wr_entry(9, 1, mk(0, 1, 4'h5, 8'h77, t, 18'h00111, 2'b00));
        lookup({t, 6'd9, off}, 8'($urandom), 0);
        checks++;
        if (padr_o !== {18'h00333, off} || acr_o !== 4'hA) begin
            failures++; $display("FAIL next_way got padr=%h acr=%h want %h a", padr_o, acr_o, {18'h00333, off});
        end
    endtask

    task automatic test_xlate_off();
        req_i = 1; xlaten_i = 0; vadr_i = 32'hFFFC0300; asid_i = 8'($urandom);
        cyc();
        idle();
        checks++;
        if (vld_o !== 1 || padr_o !== 32'hFFFC0300 || acr_o !== 4'hF || miss_o !== 0) begin
            failures++; $display("FAIL xlate_off got vld=%b padr=%h acr=%h miss=%b want 1 fffc0300 f 0", vld_o, padr_o, acr_o, miss_o);
        end
    endtask

    task automatic test_adupd();
        logic [11:0] t3, t4;
        logic [63:0] d;
        t3 = 12'($urandom); t4 = 12'($urandom);
        wr_entry(33, 0, mk(1, 1, 4'hF, 8'h00, t3, 18'h00A00, 2'b00));
        wr_entry(34, 0, mk(1, 1, 4'h7, 8'h00, t4, 18'h00B00, 2'b00));
        lookup({t3, 6'd33, 14'h0}, 8'h55, 1);
        checks++;
        if (vld_o !== 1 || miss_o !== 0) begin
            failures++; $display("FAIL store_hit got vld=%b miss=%b want 1 0", vld_o, miss_o);
        end
        cyc();
        rd_entry(33, 0);
        checks++;
        if (rdat_o[61:60] !== (ADUPD ? 2'b11 : 2'b00)) begin
            failures++; $display("FAIL store_ad got %b want %b", rdat_o[61:60], ADUPD ? 2'b11 : 2'b00);
        end
        lookup({t4, 6'd34, 14'h0}, 8'h55, 0);
        cyc();
        rd_entry(34, 0);
        checks++;
        if (rdat_o[61:60] !== (ADUPD ? 2'b01 : 2'b00)) begin
            failures++; $display("FAIL load_ad got %b want %b", rdat_o[61:60], ADUPD ? 2'b01 : 2'b00);
        end
        d = mk(1, 1, 4'hC, 8'h00, t3, 18'h00A55, 2'b00);
        lookup({t3, 6'd33, 14'h0}, 8'h55, 1);
        wr_entry(33, 0, d);
        rd_entry(33, 0);
        checks++;
        if (rdat_o !== d) begin
            failures++; $display("FAIL wr_wins got %h want %h", rdat_o, d);
        end
    endtask

    task automatic test_flush();
        logic [11:0] ta, tb, tc;
        int n;
        ta = 12'($urandom); tb = 12'($urandom); tc = 12'($urandom);
        wr_entry(40, 0, mk(1, 0, 4'h1, 8'h12, ta, 18'h01000, 2'b00));
        wr_entry(41, 1, mk(1, 1, 4'h2, 8'h12, tb, 18'h02000, 2'b00));
        wr_entry(42, 2, mk(1, 0, 4'h3, 8'h13, tc, 18'h03000, 2'b00));
        flush_i = 1; flasid_i = 1; asid_i = 8'h12; req_i = 1; vadr_i = {tb, 6'd41, 14'h0};
        cyc();
        idle();
        checks++;
        if (vld_o !== 0) begin
            failures++; $display("FAIL flush_prio got vld=%b want 0", vld_o);
        end
        for (int s = 0; s < 64; s++)
            for (int w = 0; w < 4; w++)
                if (!mm[s][w][62] && mm[s][w][55:48] == 8'h12) mm[s][w][63] = 1'b0;
        wr_i = 1; wset_i = 6'd42; wway_i = 2'd2; wdat_i = '0;
        wait_ready(n);
        idle();
        checks++;
        if (n != 64) begin
            failures++; $display("FAIL flush_len got %0d busy cycles want 64", n);
        end
        lookup({ta, 6'd40, 14'h0}, 8'h12, 0);
        checks++;
        if (miss_o !== 1) begin
            failures++; $display("FAIL flush_local got miss=%b want 1", miss_o);
        end
        lookup({tb, 6'd41, 14'h0}, 8'h12, 0);
        checks++;
        if (miss_o !== 0 || acr_o !== 4'h2) begin
            failures++; $display("FAIL flush_global got miss=%b acr=%h want 0 2", miss_o, acr_o);
        end
        lookup({tc, 6'd42, 14'h0}, 8'h13, 0);
        checks++;
        if (miss_o !== 0 || acr_o !== 4'h3) begin
            failures++; $display("FAIL flush_other got miss=%b acr=%h want 0 3", miss_o, acr_o);
        end
        flush_i = 1; flasid_i = 0;
        cyc();
        idle();
        for (int s = 0; s < 64; s++)
            for (int w = 0; w < 4; w++) mm[s][w][63] = 1'b0;
        wait_ready(n);
        checks++;
        if (n != 64) begin
            failures++; $display("FAIL flushall_len got %0d busy cycles want 64", n);
        end
        lookup({tb, 6'd41, 14'h0}, 8'h12, 0);
        checks++;
        if (miss_o !== 1) begin
            failures++; $display("FAIL flush_all got miss=%b want 1", miss_o);
        end
    endtask

    task automatic test_random();
        logic [11:0] tp [4];
        logic [5:0]  sp [4];
        int s, w;
        for (int i = 0; i < 4; i++) tp[i] = 12'($urandom);
        sp[0] = 6'd3; sp[1] = 6'd17; sp[2] = 6'd62; sp[3] = 6'd0;
        for (int it = 0; it < 400; it++) begin
            s = int'(sp[$urandom_range(3)]);
            w = $urandom_range(3);
            req_i    = ($urandom_range(9) < 6);
            xlaten_i = ($urandom_range(9) != 0);
            we_i     = 1'($urandom);
            asid_i   = $urandom_range(1) ? 8'h12 : 8'h13;
            vadr_i   = ($urandom_range(9) < 7) ? {tp[$urandom_range(3)], sp[$urandom_range(3)], 14'($urandom)} : $urandom;
            wr_i     = ($urandom_range(9) < 3);
            wrand_i  = ($urandom_range(3) == 0);
            wset_i   = 6'(s);
            wway_i   = 2'(w);
            wdat_i   = mk($urandom_range(3) != 0, $urandom_range(3) == 0, 4'($urandom),
                          $urandom_range(1) ? 8'h12 : 8'h13, tp[$urandom_range(3)],
                          18'($urandom), 2'($urandom));
            rd_i     = known[s][w] && ($urandom_range(9) < 3);
            cyc();
            checks++;
            if (vld_o !== exp_vld) begin
                failures++; $display("FAIL rnd_vld[%0d] got %b want %b", it, vld_o, exp_vld);
            end
            checks++;
            if (padr_o !== exp_padr || acr_o !== exp_acr || miss_o !== exp_miss) begin
                failures++;
                $display("FAIL rnd_res[%0d] got padr=%h acr=%h miss=%b want %h %h %b", it, padr_o, acr_o, miss_o, exp_padr, exp_acr, exp_miss);
            end
            if (rdat_known) begin
                checks++;
                if (rdat_o !== exp_rdat) begin
                    failures++; $display("FAIL rnd_rdat[%0d] got %h want %h", it, rdat_o, exp_rdat);
                end
            end
        end
        idle();
        cyc();
    endtask

    task automatic test_reset_abort();
        logic [11:0] t;
        logic [63:0] d;
        int n;
        t = 12'($urandom);
        wr_entry(50, 1, mk(1, 1, 4'h9, 8'h00, t, 18'h00777, 2'b00));
        req_i = 1; xlaten_i = 0; vadr_i = 32'h8000_1234 | $urandom;
        cyc();
        idle();
        checks++;
        if (vld_o !== 1) begin
            failures++; $display("FAIL abort_pre got vld=%b want 1", vld_o);
        end
        rst_ni = 0;
        #1;
        checks++;
        if (vld_o !== 0 || padr_o !== 0 || acr_o !== 0 || rdy_o !== 0) begin
            failures++; $display("FAIL async_rst got vld=%b padr=%h acr=%h rdy=%b want 0 0 0 0", vld_o, padr_o, acr_o, rdy_o);
        end
        step();
        rst_ni = 1;
        model_reset();
        wait_ready(n);
        checks++;
        if (n != 64) begin
            failures++; $display("FAIL reinit_len got %0d busy cycles want 64", n);
        end
        lookup({t, 6'd50, 14'h0}, 8'h00, 0);
        checks++;
        if (miss_o !== 1) begin
            failures++; $display("FAIL reinit_clear got miss=%b want 1", miss_o);
        end
        d = mk(0, 0, 4'h4, 8'h44, 12'($urandom), 18'($urandom), 2'b00);
        wr_i = 1; wrand_i = 1; wset_i = 6'd51; wway_i = 2'd3; wdat_i = d;
        cyc();
        idle();
        rd_entry(51, 0);
        checks++;
        if (rdat_o !== d) begin
            failures++; $display("FAIL rr_reset got %h want %h", rdat_o, d);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_rrway();
        test_write_lookup();
        test_priority();
        test_xlate_off();
        test_adupd();
        test_flush();
        test_random();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
